inst_fetch_unit: RTL and testbench

//  Instruction-fetch initiator for the single-cycle-latency instruction memory.
//  - Owns the PC and drives byte addresses to the memory.
//  - Captures the returned words into a small skid FIFO.
//  - Presents {instruction, PC} to decode over a valid/ready handshake.
//  - Handles start, end-of-program drain and branch/jump redirect with flush.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/inst_fetch_unit.sv | 135 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch slice.
//   ADDR_W / INST_W : byte-address and instruction widths
//   PC_STEP         : PC increment between sequential instruction words
//   fetch_state_t   : fetch FSM states
//   fetch_entry_t   : one fetched word together with the byte address it came from
package mips_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small skid FIFO holding fetched {inst, pc} entries for decode.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data at the tail (caller guarantees space)
//   push_data  : entry to write
//   pop        : drop the head entry (caller guarantees non-empty)
//   flush      : empty the FIFO; overrides push and pop in the same cycle
//   head       : entry at the head (meaningful while count != 0)
//   count      : number of stored entries
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem     <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch initiator for a single-cycle-latency instruction memory.
// Owns the PC, issues one address per cycle while FIFO credit allows, captures
// returned words into a skid FIFO and hands {inst, pc} to decode over valid/ready.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin fetching at RESET_PC (only from IDLE/DONE)
//   imem_addr       : byte address to memory (registered PC)
//   imem_inst       : memory read data, one cycle after the address is sampled
//   redirect_valid  : discard fetched/in-flight words and resume at redirect_pc
//   redirect_pc     : redirect target; low two bits ignored
//   out_valid/ready : decode handshake
//   out_inst/out_pc : head instruction and its byte address
//   busy / done     : state is RUN or DRAIN / state is DONE
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
    parameter logic [ADDR_W-1:0] END_ADDR = 32'd52
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              epoch_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] tag_pc_q;
    logic              tag_epoch_q;

    logic [CNT_W-1:0]  count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              active;
    logic              redirect_act;
    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W-1:0]  occupancy;

    assign active       = (state_q == RUN) || (state_q == DRAIN);
    assign redirect_act = redirect_valid && active;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // Entries the FIFO will hold once the in-flight word lands and this cycle's pop
    // retires; issuing only below DEPTH means a push never meets a full FIFO.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = (state_q == RUN) && !redirect_act && (occupancy < OCC_W'(DEPTH));

    // Words fetched before the last redirect carry the stale epoch and are dropped.
    assign push             = inflight_q && (tag_epoch_q == epoch_q);
    assign push_entry.inst  = imem_inst;
    assign push_entry.pc    = tag_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            inflight_q  <= 1'b0;
            tag_pc_q    <= '0;
            tag_epoch_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                tag_pc_q    <= pc_q;
                tag_epoch_q <= epoch_q;
                pc_q        <= pc_q + PC_STEP;
            end

            if (redirect_act) begin
                epoch_q <= ~epoch_q;
                pc_q    <= {redirect_pc[ADDR_W-1:2], 2'b00};
                state_q <= RUN;
            end else begin
                unique case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            pc_q    <= RESET_PC;
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (issue && (pc_q == END_ADDR)) begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        // Leave once nothing is in flight and the last entry is being taken.
                        if (!inflight_q && (count == CNT_W'(pop))) begin
                            state_q <= DONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_act),
        .head      (head),
        .count     (count)
    );

    assign imem_addr = pc_q;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign busy      = active;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle registered memory model
// returning words[i] = 32'hA000_0000 + i.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_inst <= 32'hA000_0000 + (imem_addr >> 2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL reset_out_inst: got %h expected 0", out_inst); end
        checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_straight_line();
        int n;
        bit seen;
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        n = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 100 && n < 14; cyc++) begin
            if (out_valid) begin
                seen = 1'b1;
                checks++; if (out_pc !== 32'(n * 4)) begin errors++; $display("FAIL straight_pc: got %h expected %h", out_pc, 32'(n * 4)); end
                checks++; if (out_inst !== 32'hA000_0000 + 32'(n)) begin errors++; $display("FAIL straight_inst: got %h expected %h", out_inst, 32'hA000_0000 + 32'(n)); end
                n++;
            end else if (seen) begin
                checks++; errors++;
                $display("FAIL straight_gap: out_valid got 0 expected 1 before word %0d", n);
            end
            if (n < 14) step();
        end
        checks++; if (n != 14) begin errors++; $display("FAIL straight_count: got %0d words expected 14", n); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL straight_done_early: got %b expected 0", done); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL straight_done: got %b expected 1", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL straight_empty: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL straight_busy: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        for (int cyc = 0; cyc < 20 && !out_valid; cyc++) step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_inst !== 32'hA000_0000) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b pc=%h inst=%h expected 1/0/a0000000", out_valid, out_pc, out_inst);
            end
            checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL bp_no_issue: imem_addr got %h expected 8", imem_addr); end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
                errors++;
                $display("FAIL bp_release: got valid=%b pc=%h expected 1/%h", out_valid, out_pc, 32'(i * 4));
            end
            if (i < 13) step();
        end
    endtask

    task automatic test_redirect();
        bit found;
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (out_valid && out_pc == 32'h4) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL redir_head4: got %b expected 1", found); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h23;
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", out_valid); end
        for (int cyc = 0; cyc < 10 && !out_valid; cyc++) step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20) begin errors++; $display("FAIL redir_target_pc: got valid=%b pc=%h expected 1/00000020", out_valid, out_pc); end
        checks++; if (out_inst !== 32'hA000_0008) begin errors++; $display("FAIL redir_target_inst: got %h expected a0000008", out_inst); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h24) begin errors++; $display("FAIL redir_next_pc: got valid=%b pc=%h expected 1/00000024", out_valid, out_pc); end
    endtask

    task automatic test_redirect_pop();
        logic [31:0] exp_seq [6];
        int k;
        bit redirected;
        exp_seq = '{32'h0, 32'h4, 32'h10, 32'h14, 32'h18, 32'h1C};
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        k = 0;
        redirected = 1'b0;
        for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
            if (out_valid) begin
                checks++; if (out_pc !== exp_seq[k]) begin errors++; $display("FAIL rpop_seq: word %0d got %h expected %h", k, out_pc, exp_seq[k]); end
                k++;
                if (!redirected && out_pc == 32'h4) begin
                    redirect_valid = 1'b1;
                    redirect_pc = 32'h10;
                    step();
                    redirect_valid = 1'b0;
                    redirected = 1'b1;
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rpop_flush: got %b expected 0", out_valid); end
                    continue;
                end
            end
            step();
        end
        checks++; if (k != 6) begin errors++; $display("FAIL rpop_count: got %0d words expected 6", k); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        repeat (5) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", busy); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL areset_addr: got %h expected 0", imem_addr); end
        step();
        rst_n = 1'b1;
        pulse_start();
        for (int cyc = 0; cyc < 10 && !out_valid; cyc++) step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_inst !== 32'hA000_0000) begin errors++; $display("FAIL areset_refetch0: got valid=%b pc=%h inst=%h expected 1/0/a0000000", out_valid, out_pc, out_inst); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd4) begin errors++; $display("FAIL areset_refetch4: got valid=%b pc=%h expected 1/4", out_valid, out_pc); end
    endtask

    task automatic test_ignored();
        int n;
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 14; cyc++) begin
            start = (cyc == 2 || cyc == 6);
            if (out_valid) begin
                checks++; if (out_pc !== 32'(n * 4)) begin errors++; $display("FAIL ign_pc: got %h expected %h", out_pc, 32'(n * 4)); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b expected 1", busy); end
                n++;
            end
            if (n < 14) step();
        end
        start = 1'b0;
        checks++; if (n != 14) begin errors++; $display("FAIL ign_count: got %0d words expected 14", n); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b expected 1", done); end
        checks++; if (imem_addr !== 32'd56) begin errors++; $display("FAIL ign_end_pc: got %h expected 38", imem_addr); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'd56) begin
                errors++;
                $display("FAIL ign_redirect_done: got done=%b busy=%b valid=%b addr=%h expected 1/0/0/38", done, busy, out_valid, imem_addr);
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_async_reset();
        test_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
